// File: rtl/matrix_op_slave_if.sv
// matrix_op_slave_if: system bus port of the matrix op slave (select, direction, address, data).
interface matrix_op_slave_if #(parameter int DATA_W = 32);
    logic              S_sel;
    logic              S_wr;
    logic [7:0]        S_address;
    logic [DATA_W-1:0] S_din;
    logic [DATA_W-1:0] S_dout;
    modport master (output S_sel, S_wr, S_address, S_din, input S_dout);
    modport slave (input S_sel, S_wr, S_address, S_din, output S_dout);
endinterface

// File: rtl/matrix_op_slave.sv
// matrix_op_slave: register map, operand streaming and multiply/add sequencing for the matrix datapath.
// MATSLV_AUTO_ADD_EN: when defined, the add engine starts automatically once the multiply completes.
module matrix_op_slave #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    matrix_op_slave_if.slave  bus,
    output logic [DATA_W-1:0] multiplicand,
    output logic [DATA_W-1:0] multiplier,
    output logic              multiplicand_we,
    output logic              multiplier_we,
    output logic [PTR_W-1:0]  wAddr,
    output logic              multi_opstart,
    output logic              multi_opclear,
    input  logic              multi_opdone,
    output logic              adder_opstart,
    input  logic              adder_opdone,
    input  logic [DATA_W-1:0] result,
    output logic [PTR_W-1:0]  rAddr,
    output logic              m_interrupt
);
    typedef enum logic [1:0] {IDLE, MULT, ADDE, DONE} state_t;
`ifdef MATSLV_AUTO_ADD_EN
    localparam logic AUTO_ADD = 1'b1;
`else
    localparam logic AUTO_ADD = 1'b0;
`endif
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);
    state_t            state;
    logic [PTR_W:0]    a_cnt, b_cnt;
    logic [PTR_W-1:0]  rptr;
    logic              ovf, mdone, int_en, int_pend;
    logic              wr, rd, bit0;
    logic [3:0]        addr;
    logic [DATA_W-1:0] status, rdata;
    assign wr          = bus.S_sel & bus.S_wr;
    assign rd          = bus.S_sel & ~bus.S_wr;
    assign addr        = bus.S_address[3:0];
    assign bit0        = bus.S_din[0];
    assign rAddr       = rptr;
    assign m_interrupt = int_pend & int_en;
    always_comb begin
        status        = '0;
        status[18]    = AUTO_ADD;
        status[17:16] = state;
        status[15]    = ovf;
        status[14:8]  = 7'(a_cnt);
        status[6:0]   = 7'(b_cnt);
        case (addr)
            4'd2:    rdata = DATA_W'(int_en);
            4'd6:    rdata = DATA_W'(rptr);
            4'd7:    rdata = status;
            4'd8:    rdata = DATA_W'(int_pend);
            4'd9:    rdata = (state == DONE) ? result : '0;
            default: rdata = '0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            a_cnt           <= '0;
            b_cnt           <= '0;
            rptr            <= '0;
            ovf             <= 1'b0;
            mdone           <= 1'b0;
            int_en          <= 1'b0;
            int_pend        <= 1'b0;
            bus.S_dout      <= '0;
            multiplicand    <= '0;
            multiplier      <= '0;
            wAddr           <= '0;
            multiplicand_we <= 1'b0;
            multiplier_we   <= 1'b0;
            multi_opstart   <= 1'b0;
            multi_opclear   <= 1'b0;
            adder_opstart   <= 1'b0;
        end else begin
            multiplicand_we <= 1'b0;
            multiplier_we   <= 1'b0;
            multi_opstart   <= 1'b0;
            multi_opclear   <= 1'b0;
            adder_opstart   <= 1'b0;
            if (rd) bus.S_dout <= rdata;
            if (wr && addr == 4'd2) int_en <= bit0;
            // CLEAR wins over every other event in the same cycle, including adder_opdone
            if (wr && addr == 4'd5 && bit0) begin
                state         <= IDLE;
                multi_opclear <= 1'b1;
                a_cnt         <= '0;
                b_cnt         <= '0;
                ovf           <= 1'b0;
                mdone         <= 1'b0;
                rptr          <= '0;
                int_pend      <= 1'b0;
            end else begin
                if (wr && addr == 4'd0) begin
                    if (state == IDLE && a_cnt < FULL) begin
                        multiplicand    <= bus.S_din;
                        multiplicand_we <= 1'b1;
                        wAddr           <= a_cnt[PTR_W-1:0];
                        a_cnt           <= a_cnt + 1'b1;
                    end else ovf <= 1'b1;
                end
                if (wr && addr == 4'd1) begin
                    if (state == IDLE && b_cnt < FULL) begin
                        multiplier    <= bus.S_din;
                        multiplier_we <= 1'b1;
                        wAddr         <= b_cnt[PTR_W-1:0];
                        b_cnt         <= b_cnt + 1'b1;
                    end else ovf <= 1'b1;
                end
                if (wr && addr == 4'd6) rptr <= bus.S_din[PTR_W-1:0];
                else if (rd && addr == 4'd9) rptr <= rptr + 1'b1;
                // the engine-done set below overrides a same-cycle W1C
                if (wr && addr == 4'd8 && bit0) int_pend <= 1'b0;
                case (state)
                    IDLE: if (wr && addr == 4'd3 && bit0 && a_cnt == FULL && b_cnt == FULL) begin
                        state         <= MULT;
                        multi_opstart <= 1'b1;
                        mdone         <= 1'b0;
                    end
                    MULT: begin
                        if (multi_opdone) mdone <= 1'b1;
`ifdef MATSLV_AUTO_ADD_EN
                        if (multi_opdone || mdone) begin
`else
                        if (wr && addr == 4'd4 && bit0 && mdone) begin
`endif
                            state         <= ADDE;
                            adder_opstart <= 1'b1;
                        end
                    end
                    ADDE: if (adder_opdone) begin
                        state    <= DONE;
                        int_pend <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_matrix_op_slave.sv
// tb_matrix_op_slave: directed plus randomized bench for matrix_op_slave (default build),
// checked against a register-level reference model of counts, flags, phase and read pointer.
module tb_matrix_op_slave;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int PTR_W  = 3;
    logic clk = 1'b0;
    logic reset = 1'b1;
    matrix_op_slave_if #(.DATA_W(DATA_W)) bus ();
    logic [DATA_W-1:0] multiplicand, multiplier, result;
    logic              multiplicand_we, multiplier_we;
    logic [PTR_W-1:0]  wAddr, rAddr;
    logic              multi_opstart, multi_opclear, multi_opdone, adder_opstart, adder_opdone, m_interrupt;
    logic [DATA_W-1:0] res_mem [DEPTH];
    logic [DATA_W-1:0] v;
    int n_assert = 0;
    int n_fail = 0;
    // reference model: phase 0 idle, 1 multiply, 2 add, 3 done
    int m_a, m_b, m_ptr, m_state;
    bit m_ovf;
    always #5 clk = ~clk;
    assign result = res_mem[rAddr];
    matrix_op_slave #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .multiplicand_we(multiplicand_we), .multiplier_we(multiplier_we), .wAddr(wAddr),
        .multi_opstart(multi_opstart), .multi_opclear(multi_opclear), .multi_opdone(multi_opdone),
        .adder_opstart(adder_opstart), .adder_opdone(adder_opdone),
        .result(result), .rAddr(rAddr), .m_interrupt(m_interrupt)
    );
    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [7:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        bus.S_sel = 1'b1; bus.S_wr = 1'b1; bus.S_address = a; bus.S_din = d;
        tick();
        bus.S_sel = 1'b0; bus.S_wr = 1'b0;
    endtask
    task automatic rd(input logic [7:0] a, output logic [DATA_W-1:0] d);
        @(negedge clk);
        bus.S_sel = 1'b1; bus.S_wr = 1'b0; bus.S_address = a; bus.S_din = '0;
        tick();
        bus.S_sel = 1'b0;
        d = bus.S_dout;
        if (a[3:0] == 4'd9) m_ptr = (m_ptr + 1) % DEPTH;
    endtask
    function automatic logic [DATA_W-1:0] status_exp();
        return DATA_W'((m_state << 16) + (int'(m_ovf) << 15) + (m_a << 8) + m_b);
    endfunction
    task automatic check_status(input string tag);
        logic [DATA_W-1:0] s;
        rd(8'd7, s);
        check(tag, s, status_exp());
    endtask
    task automatic model_clear();
        m_a = 0; m_b = 0; m_ovf = 0; m_ptr = 0; m_state = 0;
    endtask
    task automatic clear_all();
        wr(8'd5, 1);
        model_clear();
        check("clear_pulse", multi_opclear, 1);
        tick();
        check("clear_once", multi_opclear, 0);
    endtask
    task automatic load(input int off, input int n);
        logic [DATA_W-1:0] d;
        int cnt;
        for (int i = 0; i < n; i++) begin
            cnt = (off == 0) ? m_a : m_b;
            d = $urandom;
            wr(8'(off), d);
            if (m_state == 0 && cnt < DEPTH) begin
                check("store_we", (off == 0) ? multiplicand_we : multiplier_we, 1);
                check("store_wAddr", wAddr, cnt);
                check("store_data", (off == 0) ? multiplicand : multiplier, d);
                if (off == 0) m_a++; else m_b++;
            end else begin
                check("drop_we", multiplicand_we | multiplier_we, 0);
                m_ovf = 1;
            end
        end
    endtask
    task automatic start_try();
        bit go;
        go = (m_state == 0 && m_a == DEPTH && m_b == DEPTH);
        wr(8'd3, 1);
        check("start_pulse", multi_opstart, go);
        if (go) m_state = 1;
        tick();
        check("start_once", multi_opstart, 0);
    endtask
    task automatic mult_done();
        @(negedge clk);
        multi_opdone = 1'b1;
        tick();
        multi_opdone = 1'b0;
        check("no_auto_add", adder_opstart, 0);
    endtask
    task automatic add_start_ok();
        wr(8'd4, 1);
        check("add_pulse", adder_opstart, 1);
        m_state = 2;
        tick();
        check("add_once", adder_opstart, 0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
    initial begin
        bus.S_sel = 1'b0; bus.S_wr = 1'b0; bus.S_address = '0; bus.S_din = '0;
        multi_opdone = 1'b0; adder_opdone = 1'b0;
        for (int i = 0; i < DEPTH; i++) res_mem[i] = $urandom;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", bus.S_dout, 0);
        check("rst_strobes", {multiplicand_we, multiplier_we, multi_opstart, multi_opclear, adder_opstart, m_interrupt}, 0);
        check("rst_rAddr", rAddr, 0);
        @(negedge clk);
        reset = 1'b0;
        check_status("status_after_reset");
        rd(8'd9, v);
        check("result_idle", v, 0);
        check("rAddr_after_idle_read", rAddr, m_ptr);
        load(0, 5);
        start_try();
        check_status("short_start_ignored");
        clear_all();
        check_status("status_cleared");
        load(0, DEPTH);
        load(1, DEPTH);
        load(0, 1);
        check_status("status_full_ovf");
        wr(8'd2, 1);
        rd(8'd2, v);
        check("int_en_rb", v, 1);
        start_try();
        check_status("status_mult");
        wr(8'd4, 1);
        check("early_add_ignored", adder_opstart, 0);
        check_status("still_mult");
        mult_done();
        add_start_ok();
        check_status("status_adde");
        @(negedge clk);
        adder_opdone = 1'b1;
        tick();
        adder_opdone = 1'b0;
        m_state = 3;
        check("irq_set", m_interrupt, 1);
        rd(8'd8, v);
        check("int_pend_rb", v, 1);
        check_status("status_done");
        wr(8'd8, 1);
        check("irq_w1c", m_interrupt, 0);
        wr(8'd6, 6);
        m_ptr = 6;
        check("rptr_wr", rAddr, 6);
        for (int i = 0; i < 3; i++) begin
            int p;
            p = m_ptr;
            rd(8'd9, v);
            check("result_data", v, res_mem[p]);
            check("result_rAddr", rAddr, m_ptr);
        end
        rd(8'd6, v);
        check("rptr_rb", v, m_ptr);
        rd(8'd12, v);
        check("unmapped_read", v, 0);
        for (int r = 0; r < 4; r++) begin
            clear_all();
            load(0, $urandom_range(0, 10));
            load(1, $urandom_range(0, 10));
            check_status("rand_status_load");
            start_try();
            check_status("rand_status_start");
        end
        clear_all();
        load(0, DEPTH);
        load(1, DEPTH);
        start_try();
        mult_done();
        add_start_ok();
        @(negedge clk);
        adder_opdone = 1'b1;
        bus.S_sel = 1'b1; bus.S_wr = 1'b1; bus.S_address = 8'd5; bus.S_din = 1;
        tick();
        adder_opdone = 1'b0;
        bus.S_sel = 1'b0; bus.S_wr = 1'b0;
        model_clear();
        check("clear_vs_done_pulse", multi_opclear, 1);
        check("clear_vs_done_irq", m_interrupt, 0);
        check_status("clear_vs_done_status");
        rd(8'd8, v);
        check("clear_vs_done_pend", v, 0);
        rd(8'd2, v);
        check("int_en_kept", v, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
